// File: rtl/ffd_synchro_bus.sv
// ffd_synchro_bus: multi-bit flop-chain synchroniser with an optional per-bit
// stability filter and per-bit rising/falling edge event pulses.
// Every bit is an independent channel; no coherency is implied across bits.

module ffd_synchro_bus #(
  parameter int              WIDTH         = 1,
  parameter int              STAGES        = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int              FILTER_CYCLES = 0
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  // Synchroniser chain; index 0 samples the asynchronous input, the last
  // index is the synchronised level. Nothing sits between the flops.
  logic [WIDTH-1:0] r_sync [STAGES];
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] r_level_d;

  // Shift the input through the chain; reset loads every stage asynchronously.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      for (int k = 0; k < STAGES; k++) begin
        r_sync[k] <= RESET_VALUE;
      end
    end else begin
      r_sync[0] <= data_i;
      for (int k = 1; k < STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_sync = r_sync[STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_nofilter
      // Without a filter the output is the last chain flop itself.
      assign w_level = w_sync;
    end else begin : g_filter
      localparam int              CW   = $clog2(FILTER_CYCLES + 1);
      localparam logic [CW-1:0]   LP_N = CW'(FILTER_CYCLES);

      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [CW-1:0] r_count;
        logic          r_level;

        // A new level must be seen at the chain output on N+1 consecutive
        // edges before it is accepted; any agreement restarts the count, so
        // the counter saturates at N and never wraps.
        always_ff @(posedge aclk or negedge arstn) begin
          if (!arstn) begin
            r_count <= '0;
            r_level <= RESET_VALUE[gi];
          end else if (w_sync[gi] == r_level) begin
            r_count <= '0;
          end else if (r_count == LP_N) begin
            r_level <= w_sync[gi];
            r_count <= '0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end

        assign w_level[gi] = r_level;
      end
    end
  endgenerate

  // History of the output level, used only to detect its transitions.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_level_d <= RESET_VALUE;
    end else begin
      r_level_d <= w_level;
    end
  end

  // Pulses come straight from flop outputs, so they cannot glitch, and since
  // one bit cannot be both 0->1 and 1->0 they are mutually exclusive.
  assign data_o = w_level;
  assign rise_o = w_level & ~r_level_d;
  assign fall_o = ~w_level & r_level_d;

endmodule

// File: tb/tb_ffd_synchro_bus.sv
// tb_ffd_synchro_bus: exercises three configurations of ffd_synchro_bus:
// A (4 bits, 3 stages, reset 1010, no filter), B (8 bits, 2 stages, filter 3)
// and C (1 bit, 2 stages, filter 7) sharing one clock with separate resets.

module tb_ffd_synchro_bus;

  localparam int B_STAGES = 2;
  localparam int B_FILTER = 3;

  logic       aclk;
  logic       arstnA, arstnB, arstnC;
  logic [3:0] dataIA, dataOA, riseOA, fallOA;
  logic [7:0] dataIB, dataOB, riseOB, fallOB;
  logic [0:0] dataIC, dataOC, riseOC, fallOC;

  int checkCount;
  int errorCount;

  typedef struct {
    logic [3:0] din;
    logic [3:0] expData;
    logic [3:0] expRise;
    logic [3:0] expFall;
  } vecA_t;

  vecA_t vecA [22];

  ffd_synchro_bus #(.WIDTH(4), .STAGES(3), .RESET_VALUE(4'b1010), .FILTER_CYCLES(0)) dutA (
    .aclk(aclk), .arstn(arstnA), .data_i(dataIA),
    .data_o(dataOA), .rise_o(riseOA), .fall_o(fallOA)
  );

  ffd_synchro_bus #(.WIDTH(8), .STAGES(B_STAGES), .RESET_VALUE(8'h00), .FILTER_CYCLES(B_FILTER)) dutB (
    .aclk(aclk), .arstn(arstnB), .data_i(dataIB),
    .data_o(dataOB), .rise_o(riseOB), .fall_o(fallOB)
  );

  ffd_synchro_bus #(.WIDTH(1), .STAGES(2), .RESET_VALUE(1'b0), .FILTER_CYCLES(7)) dutC (
    .aclk(aclk), .arstn(arstnC), .data_i(dataIC),
    .data_o(dataOC), .rise_o(riseOC), .fall_o(fallOC)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Reference model for B: the chain is a delay queue of input samples, and a
  // bit flips when every one of the last N+1 synchronised samples disagreed
  // with the current output level.
  logic [7:0] mInQ [$];
  logic [7:0] mSHist [$];
  logic [7:0] mDo, mDd;

  always @(posedge aclk or negedge arstnB) begin
    logic [7:0] flip;
    if (!arstnB) begin
      mInQ = {};
      mSHist = {};
      for (int i = 0; i < B_STAGES; i++) mInQ.push_back(8'h00);
      for (int i = 0; i <= B_FILTER; i++) mSHist.push_back(8'h00);
      mDo = 8'h00;
      mDd = 8'h00;
    end else begin
      flip = 8'hFF;
      foreach (mSHist[j]) flip = flip & (mSHist[j] ^ mDo);
      mDd = mDo;
      mDo = mDo ^ flip;
      mInQ.push_back(dataIB);
      void'(mInQ.pop_front());
      mSHist.push_back(mInQ[0]);
      void'(mSHist.pop_front());
    end
  end

  // Upper bound on the run time so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitEdge();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] din);
    dataIA = din;
    waitEdge();
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    arstnA = 1'b0;
    arstnB = 1'b0;
    arstnC = 1'b0;
    dataIA = 4'hF;
    dataIB = 8'h00;
    dataIC = 1'b0;

    vecA[0]  = '{4'hF, 4'hA, 4'h0, 4'h0};
    vecA[1]  = '{4'hF, 4'hA, 4'h0, 4'h0};
    vecA[2]  = '{4'hF, 4'hF, 4'h5, 4'h0};
    vecA[3]  = '{4'hF, 4'hF, 4'h0, 4'h0};
    vecA[4]  = '{4'hE, 4'hF, 4'h0, 4'h0};
    vecA[5]  = '{4'hE, 4'hF, 4'h0, 4'h0};
    vecA[6]  = '{4'hE, 4'hE, 4'h0, 4'h1};
    vecA[7]  = '{4'hE, 4'hE, 4'h0, 4'h0};
    vecA[8]  = '{4'hF, 4'hE, 4'h0, 4'h0};
    vecA[9]  = '{4'hF, 4'hE, 4'h0, 4'h0};
    vecA[10] = '{4'hF, 4'hF, 4'h1, 4'h0};
    vecA[11] = '{4'hF, 4'hF, 4'h0, 4'h0};
    vecA[12] = '{4'h0, 4'hF, 4'h0, 4'h0};
    vecA[13] = '{4'h0, 4'hF, 4'h0, 4'h0};
    vecA[14] = '{4'h0, 4'h0, 4'h0, 4'hF};
    vecA[15] = '{4'h5, 4'h0, 4'h0, 4'h0};
    vecA[16] = '{4'h5, 4'h0, 4'h0, 4'h0};
    vecA[17] = '{4'h5, 4'h5, 4'h5, 4'h0};
    vecA[18] = '{4'hA, 4'h5, 4'h0, 4'h0};
    vecA[19] = '{4'hA, 4'h5, 4'h0, 4'h0};
    vecA[20] = '{4'hA, 4'hA, 4'hA, 4'h5};
    vecA[21] = '{4'hA, 4'hA, 4'h0, 4'h0};

    // ---- A: reset hold with input already at F ----
    $display("[TB] A: reset hold and latency table");
    repeat (25) begin
      waitEdge();
      checkOutput("A reset data", 32'(dataOA), 32'h0000000A);
      checkOutput("A reset rise", 32'(riseOA), 32'h0);
      checkOutput("A reset fall", 32'(fallOA), 32'h0);
    end
    arstnA = 1'b1;
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecA[i].din);
      checkOutput($sformatf("A vec%0d data", i), 32'(dataOA), 32'(vecA[i].expData));
      checkOutput($sformatf("A vec%0d rise", i), 32'(riseOA), 32'(vecA[i].expRise));
      checkOutput($sformatf("A vec%0d fall", i), 32'(fallOA), 32'(vecA[i].expFall));
    end

    // ---- C: filter of 7, reset in the middle of a pending change ----
    $display("[TB] C: mid-filter reset");
    arstnC = 1'b1;
    dataIC = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      waitEdge();
      checkOutput($sformatf("C rise-in edge%0d data", k), 32'(dataOC), (k >= 10) ? 32'h1 : 32'h0);
      checkOutput($sformatf("C rise-in edge%0d rise", k), 32'(riseOC), (k == 10) ? 32'h1 : 32'h0);
      checkOutput($sformatf("C rise-in edge%0d fall", k), 32'(fallOC), 32'h0);
    end
    dataIC = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      waitEdge();
      checkOutput($sformatf("C pending edge%0d data", k), 32'(dataOC), 32'h1);
      checkOutput($sformatf("C pending edge%0d fall", k), 32'(fallOC), 32'h0);
    end
    #2;
    arstnC = 1'b0;
    dataIC = 1'b1;
    #1;
    checkOutput("C async clear data", 32'(dataOC), 32'h0);
    checkOutput("C async clear rise", 32'(riseOC), 32'h0);
    checkOutput("C async clear fall", 32'(fallOC), 32'h0);
    repeat (3) begin
      waitEdge();
      checkOutput("C in reset data", 32'(dataOC), 32'h0);
      checkOutput("C in reset rise", 32'(riseOC), 32'h0);
      checkOutput("C in reset fall", 32'(fallOC), 32'h0);
    end
    arstnC = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      waitEdge();
      checkOutput($sformatf("C post-reset edge%0d data", k), 32'(dataOC), (k >= 10) ? 32'h1 : 32'h0);
      checkOutput($sformatf("C post-reset edge%0d rise", k), 32'(riseOC), (k == 10) ? 32'h1 : 32'h0);
      checkOutput($sformatf("C post-reset edge%0d fall", k), 32'(fallOC), 32'h0);
    end

    // ---- B: glitch rejection, acceptance, channel independence ----
    $display("[TB] B: glitch filter and channel independence");
    arstnB = 1'b1;
    dataIB = 8'h01;
    for (int k = 1; k <= 11; k++) begin
      if (k == 4) dataIB = 8'h00;
      waitEdge();
      checkOutput($sformatf("B glitch edge%0d data0", k), 32'(dataOB[0]), 32'h0);
      checkOutput($sformatf("B glitch edge%0d rise0", k), 32'(riseOB[0]), 32'h0);
      checkOutput($sformatf("B glitch edge%0d fall0", k), 32'(fallOB[0]), 32'h0);
    end
    dataIB = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      waitEdge();
      checkOutput($sformatf("B hold edge%0d data0", k), 32'(dataOB[0]), (k >= 6) ? 32'h1 : 32'h0);
      checkOutput($sformatf("B hold edge%0d rise0", k), 32'(riseOB[0]), (k == 6) ? 32'h1 : 32'h0);
      checkOutput($sformatf("B hold edge%0d fall0", k), 32'(fallOB[0]), 32'h0);
    end
    dataIB = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      waitEdge();
      checkOutput($sformatf("B release edge%0d data0", k), 32'(dataOB[0]), (k >= 6) ? 32'h0 : 32'h1);
      checkOutput($sformatf("B release edge%0d fall0", k), 32'(fallOB[0]), (k == 6) ? 32'h1 : 32'h0);
      checkOutput($sformatf("B release edge%0d rise0", k), 32'(riseOB[0]), 32'h0);
    end
    dataIB = 8'h3C;
    repeat (10) waitEdge();
    checkOutput("B static settle data", 32'(dataOB), 32'h3C);
    dataIB = 8'hBD;
    for (int k = 1; k <= 8; k++) begin
      waitEdge();
      checkOutput($sformatf("B chan edge%0d data", k), 32'(dataOB), (k >= 6) ? 32'hBD : 32'h3C);
      checkOutput($sformatf("B chan edge%0d rise", k), 32'(riseOB), (k == 6) ? 32'h81 : 32'h0);
      checkOutput($sformatf("B chan edge%0d fall", k), 32'(fallOB), 32'h0);
    end

    // ---- B: random soak against the reference model ----
    $display("[TB] B: random soak");
    for (int n = 0; n < 60; n++) begin
      int hold;
      dataIB = 8'($urandom);
      hold = int'($urandom_range(B_FILTER + 1, B_FILTER + 6));
      repeat (hold) begin
        waitEdge();
        checkOutput("B soak data", 32'(dataOB), 32'(mDo));
        checkOutput("B soak rise", 32'(riseOB), 32'(mDo & ~mDd));
        checkOutput("B soak fall", 32'(fallOB), 32'(~mDo & mDd));
        checkOutput("B soak exclusive", 32'(riseOB & fallOB), 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ffd_synchro_bus.md
Name: ffd_synchro_bus

Overview:
- Parametrised multi-bit successor to the single-bit flip-flop synchroniser.
- Brings WIDTH independent asynchronous level signals into the aclk domain through a configurable-depth flop chain.
- Adds an optional per-bit stability (glitch) filter and per-bit rising/falling-edge event pulses.
- Sits at clock-domain and pad boundaries, in front of control FSMs that need clean levels or single-cycle events.

Parameters:
- WIDTH, 1, number of independent channels.
- STAGES, 2, synchroniser flop depth per channel; legal range 2..8.
- RESET_VALUE, 0 (WIDTH bits), value of all sync flops, data_o and the history register during reset.
- FILTER_CYCLES, 0, stability filter length. 0 = filter bypassed. N>0 = a new level must persist N+1 cycles at the sync output before it propagates.

Ports:
- aclk  input  1  clock.
- arstn  input  1  reset, asynchronous, active-low.
- data_i  input  WIDTH  asynchronous level inputs; no timing relation to aclk.
- data_o  output  WIDTH  synchronised (and filtered) levels.
- rise_o  output  WIDTH  one-cycle pulse per bit on a 0->1 transition of data_o.
- fall_o  output  WIDTH  one-cycle pulse per bit on a 1->0 transition of data_o.

Behaviour:
- Reset: arstn low clears asynchronously, without waiting for aclk.
  - Sync chain, data_o and history register load RESET_VALUE.
  - Filter counters load 0.
  - rise_o and fall_o are 0.
  - Release is synchronous to the next aclk edge; no other reset handling inside.
- Sync chain: per bit, STAGES flops clocked on aclk. s[i] is the last flop. Only the first flop samples data_i; no logic is placed between chain flops.
- FILTER_CYCLES=0:
  - data_o = s, taken directly from the last flop.
  - Latency is STAGES rising edges from a stable input change to data_o.
- FILTER_CYCLES=N>0: per bit, a counter of width clog2(N+1) and a registered data_o.
  - s[i]==data_o[i]: counter <= 0.
  - s[i]!=data_o[i] and counter<N: counter <= counter+1.
  - s[i]!=data_o[i] and counter==N: data_o[i] <= s[i], counter <= 0.
  - Result: a level must differ at s for N+1 consecutive edges to pass. A glitch lasting ≤N cycles at s is fully rejected.
  - Latency is STAGES+N+1 edges.
  - The counter never exceeds N and never wraps.
- Edge pulses:
  - Register data_d <= data_o each edge; reset value is RESET_VALUE.
  - rise_o = data_o & ~data_d; fall_o = ~data_o & data_d.
  - Both are derived purely from flops, so they are glitch-free.
  - Each pulse is high exactly during the first cycle data_o holds its new value.
- Mutual exclusion: rise_o[i] and fall_o[i] are never both high. With FILTER_CYCLES>0, data_o changes at most once per N+1 cycles per bit.
- Channel independence: no shared state between bits. A simultaneous change on all bits yields simultaneous pulses on all bits.
- Reset mid-operation: any partial filter count is discarded. Pending pulses are killed, and rise_o/fall_o are low in the first cycle after release.
- Post-reset events: an input already differing from RESET_VALUE at release generates a normal edge pulse after the nominal latency. This is intended behaviour.
- Multi-bit buses: no coherency guarantee across bits. Callers needing coherent multi-bit transfer use a handshake or gray code.

Test Plan:
- Reset hold: WIDTH=4, RESET_VALUE=4'b1010, data_i=4'hF, arstn low 25 cycles.
  - Required: data_o=4'b1010, rise_o=fall_o=0 throughout.
  - After release: data_o=4'hF exactly STAGES edges later, rise_o=4'b0101 for exactly one cycle.
- Latency: STAGES=3, FILTER_CYCLES=0, data_i[0] 0->1 held.
  - Required: data_o[0] rises on the 3rd edge, rise_o[0] high one cycle.
  - On the later 1->0: fall_o[0] high one cycle, rise_o[0] stays 0.
- Glitch reject: STAGES=2, FILTER_CYCLES=3, data_i[0] high for 3 cycles then low.
  - Required: data_o[0], rise_o[0], fall_o[0] remain 0.
  - Repeating with the input held ≥4 cycles: data_o[0]=1 at edge 2+3+1=6, rise_o[0] pulses once.
- Mid-filter reset: FILTER_CYCLES=7, data_i high; assert arstn after counter reaches 4, release.
  - Required: data_o returns to RESET_VALUE immediately (asynchronously).
  - After release, a full STAGES+8 edges are required before data_o=1; no pulse during reset.
- Channel independence: WIDTH=8, toggle bits 0 and 7 simultaneously, other bits static.
  - Required: rise_o=8'h81 in one cycle, all other pulse bits 0, static bits unchanged.
- Random soak: random data_i with hold times ≥ FILTER_CYCLES+1, against a cycle-accurate reference model.
  - Required: data_o, rise_o, fall_o match every cycle; rise_o&fall_o always 0.
